jtag_host: RTL and testbench
============================

// Module: jtag_host
// PURPOSE
//  JTAG initiator: drives tck/tms/tdi/trst and samples tdo to operate an external TAP (e.g. our jtag target).
//  Accepts one command at a time (TAP reset, IR shift, DR shift, idle run) on a valid/ready port; returns captured TDO bits.
//  Runs on the system clock; TCK is a divided, registered output. Always parks the TAP in RunTestOrIdle between commands.
// PARAMETERS
//  CLK_DIV  2   clk cycles per TCK half-period (>=1); one TCK period = 2*CLK_DIV clk cycles
//  MAX_LEN  32  max bits per shift; width of cmd_data/rsp_data
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        host idle, can accept
//  cmd_op     in   2        0=OP_RESET 1=OP_SHIFT_IR 2=OP_SHIFT_DR 3=OP_RUN
//  cmd_len    in   6        shift bit count (SHIFT ops) or TCK count (RUN); >MAX_LEN clamps to MAX_LEN
//  cmd_data   in   MAX_LEN  TDI bits, bit 0 shifted first
//  rsp_valid  out  1        one-cycle pulse: command complete
//  rsp_data   out  MAX_LEN  TDO bits, bit i = i-th captured bit; unused upper bits 0
//  busy       out  1        command in progress (= !cmd_ready)
//  tck        out  1        JTAG clock
//  tms        out  1        JTAG mode select
//  tdi        out  1        JTAG data to target
//  tdo        in   1        JTAG data from target
//  trst       out  1        active-high TAP reset
// BEHAVIOUR
//  Reset values: tck=0 tms=1 tdi=0 trst=1 cmd_ready=1 busy=0 rsp_valid=0 rsp_data=0. trst drops the cycle after reset deasserts.
//  Accept on cmd_valid&&cmd_ready; op/len/data latched; cmd_ready=0 the next cycle until the cycle after the rsp_valid pulse.
//  TCK: idles low. Each TCK cycle = CLK_DIV clk low, then CLK_DIV clk high. tms/tdi change only on the clk edge
//   that drives tck low (or at the start of the first low phase). tdo is sampled on the clk edge that drives tck low,
//   ending a high phase.
//  FSM: S_IDLE -> S_PRE (TMS preamble) -> S_SHIFT (data bits) -> S_POST (TMS postamble) -> S_DONE -> S_IDLE.
//   OP_RESET: trst=1 for first TCK cycle; TMS 1,1,1,1,1,0 (6 TCK); no S_SHIFT.
//   OP_SHIFT_DR: pre TMS 1,0,0; shift n bits, tms=0 except last bit tms=1 (Exit1Dr); post TMS 1,0. Total n+5 TCK.
//   OP_SHIFT_IR: pre TMS 1,1,0,0; shift as DR; post TMS 1,0. Total n+6 TCK.
//   OP_RUN: n TCK cycles with tms=0, tdi=0; n=0 -> no TCK.
//  len=0 on SHIFT ops: no TCK activity; rsp_valid 1 cycle after accept, rsp_data=0.
//  S_DONE: rsp_valid=1 for exactly one clk, rsp_data held until the next accept. Entered on the clk after the final TCK falling edge.
//  Preamble/postamble patterns come from a shift register loaded per op with a length counter. Bit counter is 6 bits; no wrap.
//  reset mid-command: abort immediately; all outputs take reset values on the next edge; no rsp_valid for the aborted command.
//  cmd_valid while busy is ignored (not queued). tdo is a single registered sample; no synchronizer. tdo is treated as synchronous to tck.
// STRUCTURE
//  jtag_pkg: op encodings (OP_*), TAP state encodings shared with jtag target, preamble/postamble TMS patterns and lengths.
//  Sub-module jtag_tck_gen: CLK_DIV counter; outputs tck, rise_en, fall_en; enabled only while busy; reset/disable forces tck=0.
//  jtag_host: command latch, FSM, bit counter, TDI/TDO shift registers.
// TESTING
//  Reset held 3 cycles -> trst=1 tms=1 tck=0 throughout; cmd_ready=1; trst=0 one cycle after release.
//  OP_RESET, CLK_DIV=2 -> 6 TCK rising edges, tms 1,1,1,1,1,0, trst high for first 4 clk; rsp_valid once at clk 25 after accept.
//  OP_SHIFT_DR len=32 data=0xA5A51234, bench tdo=tdi loopback -> 37 TCK; rsp_data=0xA5A51234; tms=1 only on pre bit 0, last data bit, post bit 0.
//  OP_SHIFT_IR len=4 data=0x5 -> tms 1,1,0,0,0,0,0,1,1,0 (10 TCK); tdi bits 1,0,1,0 during shift.
//  OP_SHIFT_DR len=0 -> no tck edge; rsp_valid 1 clk after accept; rsp_data=0. OP_RUN len=3 -> 3 TCK, tms=0.
//  reset pulsed during data bit 10 of 32-bit DR shift -> outputs at reset values next clk, no rsp_valid; a following OP_RESET completes normally.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: host opcodes, IEEE 1149.1 TAP state codes, and the
// TMS preamble/postamble patterns the host plays out around each shift.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2,
        OP_RUN      = 2'd3
    } jtag_op_e;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR     = 4'h0,
        TAP_EXIT1_DR     = 4'h1,
        TAP_SHIFT_DR     = 4'h2,
        TAP_PAUSE_DR     = 4'h3,
        TAP_SELECT_IR    = 4'h4,
        TAP_UPDATE_DR    = 4'h5,
        TAP_CAPTURE_DR   = 4'h6,
        TAP_SELECT_DR    = 4'h7,
        TAP_EXIT2_IR     = 4'h8,
        TAP_EXIT1_IR     = 4'h9,
        TAP_SHIFT_IR     = 4'hA,
        TAP_PAUSE_IR     = 4'hB,
        TAP_RUN_IDLE     = 4'hC,
        TAP_UPDATE_IR    = 4'hD,
        TAP_CAPTURE_IR   = 4'hE,
        TAP_TEST_RESET   = 4'hF
    } tap_state_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SHIFT = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } host_state_e;

    // TMS patterns are played LSB first, one bit per TCK cycle.
    localparam logic [5:0] PAT_RESET   = 6'b011111;
    localparam logic [2:0] LEN_RESET   = 3'd6;
    localparam logic [5:0] PAT_IR_PRE  = 6'b000011;
    localparam logic [2:0] LEN_IR_PRE  = 3'd4;
    localparam logic [5:0] PAT_DR_PRE  = 6'b000001;
    localparam logic [2:0] LEN_DR_PRE  = 3'd3;
    localparam logic [5:0] PAT_POST    = 6'b000001;
    localparam logic [2:0] LEN_POST    = 3'd2;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk cycles low then CLK_DIV high, held low while disabled.
// rise_en/fall_en flag the clk edge on which tck toggles.
module jtag_tck_gen
    import jtag_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          wrap;

    assign wrap    = en && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_en = wrap && !tck_q;
    assign fall_en = wrap && tck_q;
    assign tck     = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            tck_d = !tck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: takes one command at a time, walks the TAP through the
// preamble/shift/postamble TMS sequence and returns the captured TDO bits.
module jtag_host
    import jtag_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               trst
);

    localparam int         IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

    host_state_e        state_q, state_d;
    jtag_op_e           op_q, op_d;
    logic [5:0]         len_q, len_d, bit_cnt_q, bit_cnt_d, len_clamp;
    logic [MAX_LEN-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic [5:0]         pat_q, pat_d;
    logic [2:0]         pat_cnt_q, pat_cnt_d;
    logic               tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
    logic               cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic               rise_seen_q, rise_seen_d;
    logic               tck_en, rise_en, fall_en, step;

    assign tck_en    = (state_q == S_PRE) || (state_q == S_SHIFT) || (state_q == S_POST);
    assign len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    // Advance only on a falling edge that closes a full high phase.
    assign step      = fall_en && rise_seen_q;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (tck_en),
        .tck     (tck),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        pat_d       = pat_q;
        pat_cnt_d   = pat_cnt_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_d      = trst_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rise_seen_d = rise_seen_q;
        if (rise_en) rise_seen_d = 1'b1;
        if (fall_en) rise_seen_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                trst_d      = 1'b0;
                rise_seen_d = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = jtag_op_e'(cmd_op);
                    len_d       = len_clamp;
                    data_d      = cmd_data;
                    rsp_data_d  = '0;
                    bit_cnt_d   = '0;
                    tdi_d       = 1'b0;
                    cmd_ready_d = 1'b0;
                    case (jtag_op_e'(cmd_op))
                        OP_RESET: begin
                            state_d   = S_PRE;
                            trst_d    = 1'b1;
                            tms_d     = PAT_RESET[0];
                            pat_d     = PAT_RESET >> 1;
                            pat_cnt_d = LEN_RESET - 3'd1;
                        end
                        OP_SHIFT_IR: begin
                            state_d   = (len_clamp == 6'd0) ? S_DONE : S_PRE;
                            tms_d     = (len_clamp == 6'd0) ? tms_q : PAT_IR_PRE[0];
                            pat_d     = PAT_IR_PRE >> 1;
                            pat_cnt_d = LEN_IR_PRE - 3'd1;
                        end
                        OP_SHIFT_DR: begin
                            state_d   = (len_clamp == 6'd0) ? S_DONE : S_PRE;
                            tms_d     = (len_clamp == 6'd0) ? tms_q : PAT_DR_PRE[0];
                            pat_d     = PAT_DR_PRE >> 1;
                            pat_cnt_d = LEN_DR_PRE - 3'd1;
                        end
                        default: begin
                            state_d = (len_clamp == 6'd0) ? S_DONE : S_SHIFT;
                            tms_d   = (len_clamp == 6'd0) ? tms_q : 1'b0;
                        end
                    endcase
                end
            end
            S_PRE: begin
                if (step) begin
                    trst_d = 1'b0;
                    if (pat_cnt_q != 3'd0) begin
                        tms_d     = pat_q[0];
                        pat_d     = pat_q >> 1;
                        pat_cnt_d = pat_cnt_q - 3'd1;
                    end else if (op_q == OP_RESET) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        tms_d   = (len_q == 6'd1);
                        tdi_d   = data_q[0];
                        data_d  = data_q >> 1;
                    end
                end
            end
            S_SHIFT: begin
                if (step) begin
                    if (op_q != OP_RUN) rsp_data_d[bit_cnt_q[IDX_W-1:0]] = tdo;
                    if (bit_cnt_q == len_q - 6'd1) begin
                        if (op_q == OP_RUN) begin
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_POST;
                            tms_d     = PAT_POST[0];
                            tdi_d     = 1'b0;
                            pat_d     = PAT_POST >> 1;
                            pat_cnt_d = LEN_POST - 3'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (op_q != OP_RUN) begin
                            // Raise TMS with the final data bit to leave Shift-xR.
                            tms_d  = (bit_cnt_q + 6'd2 == len_q);
                            tdi_d  = data_q[0];
                            data_d = data_q >> 1;
                        end
                    end
                end
            end
            S_POST: begin
                if (step) begin
                    if (pat_cnt_q != 3'd0) begin
                        tms_d     = pat_q[0];
                        pat_d     = pat_q >> 1;
                        pat_cnt_d = pat_cnt_q - 3'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            pat_cnt_q   <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rise_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_q      <= trst_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rise_seen_q <= rise_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        len_q  <= len_d;
        data_q <= data_d;
        pat_q  <= pat_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = !cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst      = trst_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host with TDO looped back to TDI; TCK rising edges
// are logged with the TMS/TDI seen by the target and checked against tables.
module tb_jtag_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo, trst;
    logic [31:0] rsp_data;

    assign tdo = tdi;

    always #5 clk = ~clk;

    jtag_host #(.CLK_DIV(2), .MAX_LEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .trst      (trst)
    );

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        int          ntck;
        int          rsp_k;
        logic [31:0] rsp;
        logic [63:0] tms_pat;
        logic [63:0] tdi_pat;
        int          trst_cnt;
    } vec_t;

    vec_t vecs[9];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] got_tms, got_tdi;
    logic [31:0] got_rsp;
    int          got_rise, got_rsp_k, got_rsp_cnt, got_trst, got_ready_k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int  w;
        logic prev_tck;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        got_tms     = '0;
        got_tdi     = '0;
        got_rsp     = '0;
        got_rise    = 0;
        got_rsp_k   = -1;
        got_rsp_cnt = 0;
        got_trst    = 0;
        got_ready_k = -1;
        prev_tck    = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (tck && !prev_tck) begin
                if (got_rise < 64) begin
                    got_tms[got_rise] = tms;
                    got_tdi[got_rise] = tdi;
                end
                got_rise++;
            end
            prev_tck = tck;
            if (trst) got_trst++;
            if (rsp_valid) begin
                got_rsp_cnt++;
                got_rsp_k = k;
                got_rsp   = rsp_data;
            end
            if (cmd_ready && k > 0) begin
                got_ready_k = k;
                break;
            end
            // A command offered while busy must be dropped.
            cmd_valid = (k == 2);
            cmd_op    = 2'd3;
            cmd_len   = 6'd7;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_vec(input int i);
        do_cmd(vecs[i].op, vecs[i].len, vecs[i].data);
        chk($sformatf("v%0d_tck_rises", i), 64'(got_rise), 64'(vecs[i].ntck));
        chk($sformatf("v%0d_rsp_cycle", i), 64'(got_rsp_k), 64'(vecs[i].rsp_k));
        chk($sformatf("v%0d_rsp_pulses", i), 64'(got_rsp_cnt), 64'd1);
        chk($sformatf("v%0d_rsp_data", i), {32'd0, got_rsp}, {32'd0, vecs[i].rsp});
        chk($sformatf("v%0d_tms", i), got_tms, vecs[i].tms_pat);
        chk($sformatf("v%0d_tdi", i), got_tdi, vecs[i].tdi_pat);
        chk($sformatf("v%0d_trst_cycles", i), 64'(got_trst), 64'(vecs[i].trst_cnt));
        chk($sformatf("v%0d_ready_cycle", i), 64'(got_ready_k), 64'(vecs[i].rsp_k + 1));
        chk($sformatf("v%0d_rsp_held", i), {32'd0, rsp_data}, {32'd0, vecs[i].rsp});
        chk($sformatf("v%0d_busy_idle", i), {62'd0, busy, tck}, 64'd0);
    endtask

    initial begin
        int rises, rsp_seen, tck_seen;
        logic prev_tck;

        //           op     len    data          ntck rsp_k rsp           tms                    tdi                    trst
        vecs[0] = '{2'd0, 6'd0,  32'h0000_0000, 6,   25,   32'h0000_0000, 64'h1F,                64'h0,                 4};
        vecs[1] = '{2'd2, 6'd32, 32'hA5A5_1234, 37,  149,  32'hA5A5_1234, 64'h0000_000C_0000_0001, 64'h0000_0005_2D28_91A0, 0};
        vecs[2] = '{2'd1, 6'd4,  32'h0000_0005, 10,  41,   32'h0000_0005, 64'h183,               64'h50,                0};
        vecs[3] = '{2'd2, 6'd0,  32'hFFFF_FFFF, 0,   1,    32'h0000_0000, 64'h0,                 64'h0,                 0};
        vecs[4] = '{2'd3, 6'd3,  32'hFFFF_FFFF, 3,   13,   32'h0000_0000, 64'h0,                 64'h0,                 0};
        vecs[5] = '{2'd2, 6'd40, 32'h8000_0001, 37,  149,  32'h8000_0001, 64'h0000_000C_0000_0001, 64'h0000_0004_0000_0008, 0};
        vecs[6] = '{2'd2, 6'd1,  32'h0000_0001, 6,   25,   32'h0000_0001, 64'h19,                64'h8,                 0};
        vecs[7] = '{2'd1, 6'd0,  32'h1234_5678, 0,   1,    32'h0000_0000, 64'h0,                 64'h0,                 0};
        vecs[8] = '{2'd3, 6'd0,  32'h0000_0000, 0,   1,    32'h0000_0000, 64'h0,                 64'h0,                 0};

        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("reset_state_c%0d", c),
                {25'd0, tck, tms, tdi, trst, cmd_ready, busy, rsp_valid, rsp_data},
                {25'd0, 7'b0101100, 32'h0});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        chk("trst_release", {62'd0, trst, cmd_ready}, 64'd1);

        for (int i = 0; i < 9; i++) check_vec(i);

        // Abort a 32-bit DR shift during data bit 10 (the 14th TCK rise).
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_len   = 6'd32;
        cmd_data  = 32'hFFFF_0000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rises     = 0;
        prev_tck  = 1'b0;
        for (int k = 0; k < 200 && rises < 14; k++) begin
            @(posedge clk); #1;
            if (tck && !prev_tck) rises++;
            prev_tck = tck;
        end
        chk("abort_reached_bit10", 64'(rises), 64'd14);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_reset_state",
            {25'd0, tck, tms, tdi, trst, cmd_ready, busy, rsp_valid, rsp_data},
            {25'd0, 7'b0101100, 32'h0});
        reset    = 1'b0;
        rsp_seen = 0;
        tck_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_seen++;
            if (tck) tck_seen++;
        end
        chk("abort_no_rsp", 64'(rsp_seen), 64'd0);
        chk("abort_no_tck", 64'(tck_seen), 64'd0);
        chk("abort_idle", {61'd0, cmd_ready, busy, trst}, 64'b100);
        check_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
